// File: rtl/disp_pkg.sv
// Shared defaults, colour constants and fill FSM state type for the display framebuffer.
package disp_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int RGB_W_DEF = 12;

  // Coordinate widths are fixed by the scan-out timing block, not by the buffer size.
  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam logic [11:0] BG_COLOR_DEF = 12'h000;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_RED   = 12'hF00;
  localparam logic [11:0] COL_GREEN = 12'h0F0;
  localparam logic [11:0] COL_BLUE  = 12'h00F;
  localparam logic [11:0] COL_WHITE = 12'hFFF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/disp_framebuf_if.sv
// Write, fill and scan-out signal bundle between an application/VGA master and the framebuffer.
interface disp_framebuf_if
  import disp_pkg::*;
#(
  parameter int RGB_W = RGB_W_DEF
) ();

  logic             wr_valid;
  logic             wr_ready;
  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;
  logic [RGB_W-1:0] wr_data;

  logic             fill_start;
  logic [RGB_W-1:0] fill_color;
  logic             fill_busy;
  logic             fill_done;

  logic             rd_en;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             rd_valid;
  logic [RGB_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data,
    output fill_start, fill_color,
    output rd_en, rd_x, rd_y,
    input  wr_ready, fill_busy, fill_done,
    input  rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data,
    input  fill_start, fill_color,
    input  rd_en, rd_x, rd_y,
    output wr_ready, fill_busy, fill_done,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/disp_sdp_ram.sv
// Simple dual-port RAM: port A write-only, port B registered read-first read.
module disp_sdp_ram #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 307200
) (
  input  logic              i_clk,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_b_data;

  // Port A write.
  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_data;
  end

  // Port B read; samples the array before a same-edge write lands, so it returns old data.
  always_ff @(posedge i_clk) begin
    r_b_data <= r_mem[i_b_addr];
  end

  assign o_b_data = r_b_data;

endmodule

// File: rtl/disp_framebuf.sv
// Parametrised display framebuffer: coordinate writes, full-screen fill engine,
// 2-cycle scan-out read with optional power-of-two upscale and background colour.
module disp_framebuf
  import disp_pkg::*;
#(
  parameter int               H_RES    = H_RES_DEF,
  parameter int               V_RES    = V_RES_DEF,
  parameter int               RGB_W    = RGB_W_DEF,
  parameter int               SCALE    = 0,
  parameter logic [RGB_W-1:0] BG_COLOR = RGB_W'(BG_COLOR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  disp_framebuf_if.slave  bus
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);

  // One spare bit so y*H_RES+x is never truncated before the range check.
  typedef logic [ADDR_W:0] addr_ext_t;

  localparam addr_ext_t         H_X     = addr_ext_t'(H_RES);
  localparam addr_ext_t         DEPTH_X = addr_ext_t'(DEPTH);
  localparam logic [31:0]       H_U     = 32'(H_RES);
  localparam logic [31:0]       V_U     = 32'(V_RES);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fill_state_e       r_state;
  fill_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [RGB_W-1:0]  r_fill_color;
  logic              r_fill_done;
  logic              w_done_nxt;
  logic              w_start;

  logic              w_wr_ready;
  addr_ext_t         w_wr_full;
  logic              w_wr_in;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [RGB_W-1:0]  w_ram_wdata;

  logic [X_W-1:0]    w_rd_sx;
  logic [Y_W-1:0]    w_rd_sy;
  addr_ext_t         w_rd_full;
  logic              w_rd_in;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [RGB_W-1:0]  w_ram_q;

  logic              r_en1;
  logic              r_in1;
  logic              r_en2;
  logic              r_in2;
  logic [RGB_W-1:0]  r_q;

  assign w_wr_full = addr_ext_t'(bus.wr_y) * H_X + addr_ext_t'(bus.wr_x);
  // The full-address term only matters if the narrowed coordinates alias; it keeps every bit checked.
  assign w_wr_in   = (32'(bus.wr_x) < H_U) && (32'(bus.wr_y) < V_U) && (w_wr_full < DEPTH_X);

  // Fill FSM next state, write-port mux and handshake; reset blocks any write in its cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done_nxt  = 1'b0;
    w_wr_ready  = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_waddr = w_wr_full[ADDR_W-1:0];
    w_ram_wdata = bus.wr_data;
    case (r_state)
      IDLE: begin
        w_wr_ready = 1'b1;
        w_ram_we   = bus.wr_valid && w_wr_in;
        if (bus.fill_start) begin
          w_start     = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_cnt;
        w_ram_wdata = r_fill_color;
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_wr_ready = 1'b0;
      w_ram_we   = 1'b0;
    end
  end

  // Fill FSM state, address counter, latched colour and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fill_color <= '0;
      r_fill_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_done <= w_done_nxt;
      if (w_start) begin
        r_cnt        <= '0;
        r_fill_color <= bus.fill_color;
      end else if (r_state == FILL) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.wr_ready  = w_wr_ready;
  assign bus.fill_busy = (r_state == FILL);
  assign bus.fill_done = r_fill_done;

  assign w_rd_sx   = bus.rd_x >> SCALE;
  assign w_rd_sy   = bus.rd_y >> SCALE;
  assign w_rd_full = addr_ext_t'(w_rd_sy) * H_X + addr_ext_t'(w_rd_sx);
  assign w_rd_in   = (32'(w_rd_sx) < H_U) && (32'(w_rd_sy) < V_U) && (w_rd_full < DEPTH_X);
  // Out-of-range reads park on address 0; their data is replaced by BG_COLOR anyway.
  assign w_rd_addr = w_rd_in ? w_rd_full[ADDR_W-1:0] : '0;

  disp_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (RGB_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk    (clk),
    .i_a_we   (w_ram_we),
    .i_a_addr (w_ram_waddr),
    .i_a_data (w_ram_wdata),
    .i_b_addr (w_rd_addr),
    .o_b_data (w_ram_q)
  );

  // Stage 1: request flags travel alongside the RAM's own registered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en1 <= 1'b0;
      r_in1 <= 1'b0;
    end else begin
      r_en1 <= bus.rd_en;
      r_in1 <= w_rd_in;
    end
  end

  // Stage 2: register the RAM word with its flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en2 <= 1'b0;
      r_in2 <= 1'b0;
      r_q   <= '0;
    end else begin
      r_en2 <= r_en1;
      r_in2 <= r_in1;
      r_q   <= w_ram_q;
    end
  end

  assign bus.rd_valid = r_en2;
  assign bus.rd_data  = r_en2 ? (r_in2 ? r_q : BG_COLOR) : '0;

endmodule
